// File: rtl/game_reset_sequencer_pkg.sv
// Shared Games package: game-code enum, default sequencer timing and the
// state encoding used by the reset sequencer.
package game_reset_sequencer_pkg;

  typedef enum logic [3:0] {
    GAME_PONG     = 4'd0,
    GAME_BREAKOUT = 4'd1,
    GAME_INVADERS = 4'd2,
    GAME_ASTEROID = 4'd3,
    GAME_PACMAN   = 4'd4,
    GAME_TETRIS   = 4'd5,
    GAME_SNAKE    = 4'd6,
    GAME_FROGGER  = 4'd7,
    GAME_DIAG     = 4'd15
  } game_code_e;

  // 10 ms of stability at 50 MHz before an input is believed.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_SETUP_CYCLES    = 16;
  localparam int unsigned DEF_PULSE_CYCLES    = 1024;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_reset_sequencer_debouncer.sv
// Two-flop synchroniser followed by a saturating stability counter; the
// stable value only moves after CYCLES consecutive matching samples.
module game_reset_sequencer_debouncer #(
  parameter int unsigned          WIDTH   = 4,
  parameter int unsigned          CYCLES  = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             valid_o
);

  localparam int unsigned     CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter parks at CNT_LAST so a long-held value never wraps around.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = cand_q;
      valid_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q   <= RST_VAL;
      cnt_q    <= '0;
      stable_q <= RST_VAL;
      valid_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
    end
  end

  assign stable_o = stable_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/game_reset_sequencer.sv
// Presents a debounced game code and wraps every code change or user reset
// in a setup/pulse sequence on sys_rst_n so the selector latches cleanly.
module game_reset_sequencer
  import game_reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  input  logic       btn_reset_n,
  output logic [3:0] sw_out,
  output logic       sys_rst_n,
  output logic       busy,
  output logic       seq_done
);

  localparam int unsigned      SEQ_W      = $clog2(max_u(SETUP_CYCLES, PULSE_CYCLES) + 1);
  localparam logic [SEQ_W-1:0] SETUP_LAST = SEQ_W'(SETUP_CYCLES - 1);
  localparam logic [SEQ_W-1:0] PULSE_LAST = SEQ_W'(PULSE_CYCLES - 1);

  logic [3:0] sw_stable;
  logic       sw_vld;
  logic       btn_stable;
  logic       btn_vld;
  logic       btn_prev_q;
  logic       btn_fall;

  logic [1:0]       state_q, state_d;
  logic [3:0]       sw_out_q, sw_out_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             busy_q, busy_d;
  logic             seq_done_q, seq_done_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;

  game_reset_sequencer_debouncer #(
    .WIDTH   (4),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (4'b0000)
  ) u_sw_db (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raw_i    (sw_raw),
    .stable_o (sw_stable),
    .valid_o  (sw_vld)
  );

  // Button idles high, so its whole chain resets to "released".
  game_reset_sequencer_debouncer #(
    .WIDTH   (1),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b1)
  ) u_btn_db (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raw_i    (btn_reset_n),
    .stable_o (btn_stable),
    .valid_o  (btn_vld)
  );

  assign btn_fall = btn_vld & btn_prev_q & ~btn_stable;

  always_comb begin
    state_d     = state_q;
    sw_out_d    = sw_out_q;
    sys_rst_n_d = sys_rst_n_q;
    seq_done_d  = 1'b0;
    seq_cnt_d   = seq_cnt_q;
    case (state_q)
      ST_INIT: begin
        sys_rst_n_d = 1'b0;
        seq_cnt_d   = '0;
        if (sw_vld) begin
          sw_out_d    = sw_stable;
          sys_rst_n_d = 1'b1;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (seq_cnt_q == SETUP_LAST) begin
          sys_rst_n_d = 1'b0;
          seq_cnt_d   = '0;
          state_d     = ST_HOLD;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      ST_HOLD: begin
        if (seq_cnt_q == PULSE_LAST) begin
          sys_rst_n_d = 1'b1;
          seq_done_d  = 1'b1;
          seq_cnt_d   = '0;
          state_d     = ST_RUN;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      ST_RUN: begin
        // A switch change wins over a simultaneous press; both start one sequence.
        sys_rst_n_d = 1'b1;
        seq_cnt_d   = '0;
        if (sw_stable != sw_out_q) begin
          sw_out_d = sw_stable;
          state_d  = ST_SETUP;
        end else if (btn_fall) begin
          state_d = ST_SETUP;
        end
      end
      default: begin
        sys_rst_n_d = 1'b0;
        seq_cnt_d   = '0;
        state_d     = ST_INIT;
      end
    endcase
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sw_out_q    <= 4'b0000;
      sys_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      seq_done_q  <= 1'b0;
      seq_cnt_q   <= '0;
      btn_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sw_out_q    <= sw_out_d;
      sys_rst_n_q <= sys_rst_n_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      seq_cnt_q   <= seq_cnt_d;
      btn_prev_q  <= btn_stable;
    end
  end

  assign sw_out    = sw_out_q;
  assign sys_rst_n = sys_rst_n_q;
  assign busy      = busy_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_game_reset_sequencer.sv
// Directed and randomized bench for game_reset_sequencer, checked every
// cycle against a window/elapsed-time reference model.
module tb_game_reset_sequencer;

  localparam int D = 8;
  localparam int S = 4;
  localparam int P = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic       btn_reset_n;
  logic [3:0] sw_out;
  logic       sys_rst_n;
  logic       busy;
  logic       seq_done;

  always #5 clk = ~clk;

  game_reset_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .SETUP_CYCLES    (S),
    .PULSE_CYCLES    (P)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw      (sw_raw),
    .btn_reset_n (btn_reset_n),
    .sw_out      (sw_out),
    .sys_rst_n   (sys_rst_n),
    .busy        (busy),
    .seq_done    (seq_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int low_cnt  = 0;

  // Reference model: raw sample history per input, debounced value is the
  // value of a full window of D+1 equal samples taken two clocks earlier.
  logic [3:0] m_swh[$];
  logic [3:0] m_btnh[$];
  logic [3:0] m_sst;
  bit         m_svld;
  logic       m_bst;
  logic       m_bprev;
  bit         m_bvld;
  bit         m_init;
  bit         m_seq;
  bit         m_done;
  int         m_t;
  logic [3:0] m_swout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit window_ok(input logic [3:0] q[$], output logic [3:0] v);
    int l;
    l = q.size();
    v = 4'b0000;
    if (l - 3 - D < 0) return 1'b0;
    v = q[l-3];
    for (int i = l - 3 - D; i < l - 3; i++)
      if (q[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_swh   = {4'b0000, 4'b0000, 4'b0000};
    m_btnh  = {4'b0001, 4'b0001, 4'b0001};
    m_sst   = 4'b0000;
    m_svld  = 1'b0;
    m_bst   = 1'b1;
    m_bprev = 1'b1;
    m_bvld  = 1'b0;
    m_init  = 1'b1;
    m_seq   = 1'b0;
    m_done  = 1'b0;
    m_t     = 0;
    m_swout = 4'b0000;
  endtask

  task automatic model_edge();
    bit         bfall;
    logic [3:0] v;
    if (!rst_n) return;
    bfall  = m_bprev && !m_bst && m_bvld;
    m_done = 1'b0;
    if (m_init) begin
      if (m_svld) begin
        m_swout = m_sst;
        m_init  = 1'b0;
        m_seq   = 1'b1;
        m_t     = 0;
      end
    end else if (m_seq) begin
      m_t++;
      if (m_t == S + P) begin
        m_seq  = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_sst != m_swout) begin
      m_swout = m_sst;
      m_seq   = 1'b1;
      m_t     = 0;
    end else if (bfall) begin
      m_seq = 1'b1;
      m_t   = 0;
    end
    m_bprev = m_bst;
    m_swh.push_back(sw_raw);
    m_btnh.push_back({3'b000, btn_reset_n});
    if (m_swh.size() > D + 3) void'(m_swh.pop_front());
    if (m_btnh.size() > D + 3) void'(m_btnh.pop_front());
    if (window_ok(m_swh, v)) begin
      m_sst  = v;
      m_svld = 1'b1;
    end
    if (window_ok(m_btnh, v)) begin
      m_bst  = v[0];
      m_bvld = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("sw_out", sw_out, m_swout);
    chk("sys_rst_n", sys_rst_n, !m_init && !(m_seq && m_t >= S));
    chk("busy", busy, m_init || m_seq);
    chk("seq_done", seq_done, m_done);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (seq_done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (sys_rst_n === 1'b0) low_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_sw_out", sw_out, 4'b0000);
    chk("rst_sys_rst_n", sys_rst_n, 1'b0);
  endtask

  // Measures one INIT->SETUP->HOLD->RUN sequence straight after reset release.
  task automatic sequence_check(input logic [3:0] exp_sw);
    int k, hi, lo, d0;
    d0 = done_cnt;
    k  = 0;
    while (sys_rst_n !== 1'b1 && k < 60) begin step(); k++; end
    chk("init_bound", k < 60, 1);
    hi = 0;
    while (sys_rst_n === 1'b1 && hi < 60) begin step(); hi++; end
    chk("setup_len", hi, S);
    chk("sw_at_fall", sw_out, exp_sw);
    lo = 0;
    while (sys_rst_n === 1'b0 && lo < 60) begin step(); lo++; end
    chk("pulse_len", lo, P);
    chk("seq_done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int k, d0, b0, l0;
    rst_n       = 1'b1;
    sw_raw      = 4'b0011;
    btn_reset_n = 1'b1;
    #2;
    assert_reset();
    chk("rst_busy", busy, 1'b1);
    chk("rst_seq_done", seq_done, 1'b0);
    steps(3);
    rst_n = 1'b1;

    // Power-up with a steady code
    sequence_check(4'b0011);
    steps(5);

    // Steady switch change while running
    sw_raw = 4'b0001;
    k = 0;
    while (sw_out !== 4'b0001 && k < 40) begin step(); k++; end
    chk("sw_latency", k, D + 4);
    d0 = done_cnt;
    steps(20);
    chk("chg_done", done_cnt - d0, 1);

    // Short switch glitch and short button press are ignored
    b0 = busy_cnt;
    l0 = low_cnt;
    sw_raw = 4'b0100;
    steps(5);
    sw_raw = 4'b0001;
    btn_reset_n = 1'b0;
    steps(7);
    btn_reset_n = 1'b1;
    steps(25);
    chk("glitch_busy", busy_cnt - b0, 0);
    chk("glitch_low", low_cnt - l0, 0);
    chk("glitch_sw", sw_out, 4'b0001);

    // Long press gives exactly one sequence
    d0 = done_cnt;
    btn_reset_n = 1'b0;
    steps(20);
    btn_reset_n = 1'b1;
    steps(40);
    chk("press_done", done_cnt - d0, 1);
    chk("press_sw", sw_out, 4'b0001);

    // Press that settles during HOLD is dropped
    d0 = done_cnt;
    sw_raw = 4'b0011;
    steps(6);
    btn_reset_n = 1'b0;
    steps(10);
    btn_reset_n = 1'b1;
    steps(50);
    chk("drop_done", done_cnt - d0, 1);

    // Switch change during HOLD triggers a back-to-back sequence
    d0 = done_cnt;
    btn_reset_n = 1'b0;
    steps(6);
    sw_raw = 4'b0111;
    steps(4);
    btn_reset_n = 1'b1;
    steps(60);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_sw", sw_out, 4'b0111);

    // Reset during HOLD aborts and the full sequence repeats
    sw_raw = 4'b0010;
    steps(18);
    chk("pre_abort_hold", {busy, sys_rst_n}, 2'b10);
    assert_reset();
    steps(3);
    rst_n = 1'b1;
    sequence_check(4'b0010);
    steps(10);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) sw_raw = 4'($urandom_range(0, 15));
      else if (r < 80) btn_reset_n = ~btn_reset_n;
      else if (r < 83) begin
        assert_reset();
        steps($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      steps($urandom_range(1, 14));
    end
    btn_reset_n = 1'b1;
    steps(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_reset_sequencer.md
GAME_RESET_SEQUENCER -- requirements
Module: game_reset_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clocks required to accept an input (10 ms at 50 MHz).
REQ-002 Parameter SETUP_CYCLES, default 16, clocks sw_out is held stable with sys_rst_n high before the reset pulse.
REQ-003 Parameter PULSE_CYCLES, default 1024, clocks sys_rst_n is held low per sequence.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sw_raw  input  4  unsynchronised game-select switches.
REQ-007 btn_reset_n  input  1  unsynchronised user reset button, active-low.
REQ-008 sw_out  output  4  debounced game code presented to the game selector.
REQ-009 sys_rst_n  output  1  emulator/game-selector reset, active-low; its falling edge latches sw_out downstream.
REQ-010 busy  output  1  high whenever state is not RUN.
REQ-011 seq_done  output  1  one-clock pulse on HOLD->RUN.

Function
REQ-012 sw_raw and btn_reset_n SHALL each pass a 2-flop synchroniser before any other use.
REQ-013 Debounce, per input group: if synced != cand then cand<=synced, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 then stable<=cand; else cnt<=cnt+1. Counter width $clog2(DEBOUNCE_CYCLES), saturating (no wrap).
REQ-014 A raw change held steady SHALL reach the stable value exactly DEBOUNCE_CYCLES+3 clocks after it is applied; any excursion shorter than DEBOUNCE_CYCLES clocks SHALL never reach it.
REQ-015 States: INIT, SETUP, HOLD, RUN. All outputs registered.
REQ-016 INIT: sys_rst_n=0; on the first clock in which the switch debouncer has accepted a value, sw_out<=stable_sw, go to SETUP.
REQ-017 SETUP: sys_rst_n=1, sw_out frozen; after SETUP_CYCLES clocks go to HOLD.
REQ-018 HOLD: sys_rst_n=0, sw_out frozen; after PULSE_CYCLES clocks go to RUN, assert seq_done for one clock.
REQ-019 RUN: sys_rst_n=1; if stable_sw != sw_out then sw_out<=stable_sw and go to SETUP; else on a debounced 1->0 edge of the button go to SETUP with sw_out unchanged.
REQ-020 A switch change and a button press in the same RUN clock SHALL start one sequence carrying the new switch value.
REQ-021 Switch changes during INIT/SETUP/HOLD SHALL NOT alter sw_out; they are picked up by the compare on the first RUN clock, producing a back-to-back sequence.
REQ-022 Button presses during SETUP/HOLD SHALL be dropped, not queued.
REQ-023 SETUP and HOLD SHALL share one sequence counter of width $clog2(max(SETUP_CYCLES,PULSE_CYCLES)+1), cleared on every state entry.
REQ-024 sys_rst_n SHALL be glitch-free: driven directly from a flop, never from decoded logic.

Reset
REQ-025 On rst_n low, asynchronously: state=INIT, sys_rst_n=0, sw_out=4'b0000, busy=1, seq_done=0, synchronisers, cand, stable and counters cleared (button stable=1, i.e. released).
REQ-026 rst_n asserted mid-sequence SHALL abort immediately to INIT; the full INIT->SETUP->HOLD sequence is re-run after release.

Structure
REQ-027 Default timing constants (DEBOUNCE_CYCLES, SETUP_CYCLES, PULSE_CYCLES) SHALL live in the shared Games package beside the game-code enum.
REQ-028 One sub-module, debouncer (parameters WIDTH, CYCLES; includes the synchroniser), SHALL be instanced twice: WIDTH=4 for switches, WIDTH=1 for the button.

Verification (DEBOUNCE_CYCLES=8, SETUP_CYCLES=4, PULSE_CYCLES=6)
REQ-029 Power-up with sw_raw=4'b0011 steady, rst_n released -> sys_rst_n low through INIT, high exactly 4 clocks, low exactly 6 clocks, then high; sw_out=4'b0011 before the falling edge; one seq_done pulse.
REQ-030 In RUN, sw_raw 0011->0001 held -> sw_out=0001 exactly 12 clocks after the change, followed by the 4-high/6-low sequence and seq_done.
REQ-031 In RUN, sw_raw glitch to 0100 lasting 5 clocks, and button low lasting 7 clocks -> no change to sw_out, sys_rst_n stays high, busy stays 0.
REQ-032 Button held low 20 clocks in RUN -> one sequence with sw_out unchanged; second press during HOLD -> dropped, exactly one seq_done.
REQ-033 Switch changed to 0111 during HOLD -> sw_out holds until RUN, then a second sequence starts on the first RUN clock with sw_out=0111.
REQ-034 rst_n pulsed low during HOLD -> immediate INIT, sw_out=0000, sys_rst_n=0; full sequence repeats after release.
